// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl
// Registered manual-transmission car controller. It owns the power state,
// the run state (NSTART/START/MOVING), the moving direction and the latched
// reverse gear. It adds hold-to-power-on, idle auto power-off, a
// clutch-guarded reverse gear, blinking turn signals and a saturating
// odometer. Every output is a flop: a decision taken on the inputs of
// cycle N becomes visible after the following rising edge.

module manual_drive_ctrl #(
  parameter int POWER_ON_HOLD = 3,   // cycles power_on must be held (>=1)
  parameter int IDLE_TIMEOUT  = 16,  // idle cycles in NSTART before power-off (>=1)
  parameter int BLINK_DIV     = 4,   // cycles per blink half-period (>=1)
  parameter int MILE_DIV      = 8,   // MOVING+throttle cycles per mile (>=1)
  parameter int MILE_W        = 8    // odometer width
) (
  input  logic              clk,
  input  logic              rst,               // asynchronous, active-low
  input  logic              power_on,
  input  logic              power_off,
  input  logic              clutch,
  input  logic              brake,
  input  logic              throttle,
  input  logic              rgs,
  input  logic              left,
  input  logic              right,
  output logic              power,
  output logic [1:0]        state,
  output logic [3:0]        moving_state,
  output logic              reverse,
  output logic              turn_left_light,
  output logic              turn_right_light,
  output logic [MILE_W-1:0] mileage
);

  // Counter widths are sized to hold the largest terminal count.
  localparam int HOLD_W  = $clog2(POWER_ON_HOLD + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam int MILE_CW = $clog2(MILE_DIV + 1);

  typedef enum logic [1:0] {
    ST_NSTART = 2'b00,
    ST_START  = 2'b01,
    ST_MOVING = 2'b10
  } run_state_e;

  typedef enum logic [3:0] {
    MV_NONE    = 4'b0000,
    MV_FORWARD = 4'b0001,
    MV_BACK    = 4'b0010,
    MV_LEFT    = 4'b0100,
    MV_RIGHT   = 4'b1000
  } move_e;

  // Registered state
  logic               r_power;
  run_state_e         r_state;
  move_e              r_moving;
  logic               r_reverse;
  logic               r_left_light;
  logic               r_right_light;
  logic [MILE_W-1:0]  r_mileage;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [MILE_CW-1:0] r_mile_cnt;

  // Next-state values
  logic               w_power_next;
  run_state_e         w_state_next;
  move_e              w_moving_next;
  logic               w_reverse_next;
  logic               w_left_light_next;
  logic               w_right_light_next;
  logic [MILE_W-1:0]  w_mileage_next;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [IDLE_W-1:0]  w_idle_next;
  logic [BLINK_W-1:0] w_blink_next;
  logic               w_phase_next;
  logic [MILE_CW-1:0] w_mile_cnt_next;

  logic w_kill;          // power-off event this cycle, whatever the cause
  logic w_idle_all_low;  // no pedal or lever touched
  logic w_blink_run;     // blink divider advances this cycle

  assign w_idle_all_low = ~(clutch | brake | throttle | rgs | left | right);

  // Direction from the gear and the turn levers; both levers mean straight on.
  function automatic move_e dir_of(input logic rev, input logic l, input logic r);
    if (rev)           return MV_BACK;
    else if (l && !r)  return MV_LEFT;
    else if (r && !l)  return MV_RIGHT;
    else               return MV_FORWARD;
  endfunction

  // Power, run state, direction, reverse gear, hold and idle counters.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_power_next   = r_power;
    w_state_next   = r_state;
    w_moving_next  = r_moving;
    w_reverse_next = r_reverse;
    w_hold_next    = '0;
    w_idle_next    = '0;
    w_kill         = 1'b0;

    if (!r_power) begin
      // Powered down: run state, direction and gear sit at their reset values.
      w_state_next   = ST_NSTART;
      w_moving_next  = MV_NONE;
      w_reverse_next = 1'b0;
      if (power_on && !power_off) begin
        if (r_hold_cnt == HOLD_W'(POWER_ON_HOLD - 1)) begin
          w_power_next = 1'b1;
        end else begin
          w_hold_next = r_hold_cnt + HOLD_W'(1);
        end
      end
    end else if (power_off) begin
      w_kill = 1'b1;
    end else begin
      unique case (r_state)
        ST_NSTART: begin
          w_moving_next = MV_NONE;
          if (throttle && !clutch) begin
            w_kill = 1'b1;                       // engine stall
          end else if (throttle && clutch && !brake && !rgs) begin
            w_state_next = ST_START;
          end else if (w_idle_all_low) begin
            if (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
              w_kill = 1'b1;                     // idle auto power-off
            end else begin
              w_idle_next = r_idle_cnt + IDLE_W'(1);
            end
          end
        end

        ST_START: begin
          w_moving_next = MV_NONE;
          if (brake) begin
            w_state_next = ST_NSTART;
          end else if (!clutch && throttle) begin
            // Levers seen on the entry cycle are honoured immediately.
            w_state_next  = ST_MOVING;
            w_moving_next = dir_of(r_reverse, left, right);
          end
        end

        ST_MOVING: begin
          if (brake) begin
            w_state_next  = ST_NSTART;
            w_moving_next = MV_NONE;
          end else if (!throttle && clutch) begin
            w_state_next  = ST_START;
            w_moving_next = MV_NONE;
          end else if (rgs != r_reverse) begin
            if (!clutch) begin
              w_kill = 1'b1;                     // gear grind
            end else begin
              w_reverse_next = rgs;
              w_moving_next  = dir_of(rgs, left, right);
            end
          end else begin
            w_moving_next = dir_of(r_reverse, left, right);
          end
        end

        default: begin
          w_state_next  = ST_NSTART;
          w_moving_next = MV_NONE;
        end
      endcase
    end

    if (w_kill) begin
      w_power_next   = 1'b0;
      w_state_next   = ST_NSTART;
      w_moving_next  = MV_NONE;
      w_reverse_next = 1'b0;
      w_hold_next    = '0;
      w_idle_next    = '0;
    end
  end

  // Blink divider/phase, turn lights and odometer, driven by the decided next state.
  always_comb begin
    w_blink_next       = '0;
    w_phase_next       = 1'b1;
    w_left_light_next  = 1'b0;
    w_right_light_next = 1'b0;
    w_mile_cnt_next    = r_mile_cnt;
    w_mileage_next     = r_mileage;

    // Phase only runs while a lever is held in MOVING; otherwise it rests at 1
    // so a fresh request lights up on its first cycle.
    w_blink_run = (r_state == ST_MOVING) && (w_state_next == ST_MOVING) &&
                  w_power_next && (left || right);
    if (w_blink_run) begin
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        w_phase_next = ~r_phase;
      end else begin
        w_blink_next = r_blink_cnt + BLINK_W'(1);
        w_phase_next = r_phase;
      end
    end

    // Lights follow the state the controller is about to enter.
    if (w_power_next) begin
      unique case (w_state_next)
        ST_NSTART: begin
          w_left_light_next  = 1'b1;
          w_right_light_next = 1'b1;
        end
        ST_START: begin
          w_left_light_next  = left;
          w_right_light_next = right;
        end
        ST_MOVING: begin
          w_left_light_next  = left  & r_phase;
          w_right_light_next = right & r_phase;
        end
        default: begin
          w_left_light_next  = 1'b0;
          w_right_light_next = 1'b0;
        end
      endcase
    end

    // Odometer prescaler; a cycle that powers the car off travels no distance.
    if ((r_state == ST_MOVING) && throttle && !w_kill) begin
      if (r_mile_cnt == MILE_CW'(MILE_DIV - 1)) begin
        w_mile_cnt_next = '0;
        if (r_mileage != {MILE_W{1'b1}}) begin
          w_mileage_next = r_mileage + MILE_W'(1);
        end
      end else begin
        w_mile_cnt_next = r_mile_cnt + MILE_CW'(1);
      end
    end
  end

  // State register with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_power       <= 1'b0;
      r_state       <= ST_NSTART;
      r_moving      <= MV_NONE;
      r_reverse     <= 1'b0;
      r_left_light  <= 1'b0;
      r_right_light <= 1'b0;
      r_mileage     <= '0;
      r_hold_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_phase       <= 1'b1;
      r_mile_cnt    <= '0;
    end else begin
      r_power       <= w_power_next;
      r_state       <= w_state_next;
      r_moving      <= w_moving_next;
      r_reverse     <= w_reverse_next;
      r_left_light  <= w_left_light_next;
      r_right_light <= w_right_light_next;
      r_mileage     <= w_mileage_next;
      r_hold_cnt    <= w_hold_next;
      r_idle_cnt    <= w_idle_next;
      r_blink_cnt   <= w_blink_next;
      r_phase       <= w_phase_next;
      r_mile_cnt    <= w_mile_cnt_next;
    end
  end

  assign power            = r_power;
  assign state            = r_state;
  assign moving_state     = r_moving;
  assign reverse          = r_reverse;
  assign turn_left_light  = r_left_light;
  assign turn_right_light = r_right_light;
  assign mileage          = r_mileage;

endmodule
